// File: rtl/rv32_pkg.sv
//------------------------------------------------------------------------------
// rv32_pkg : shared RV32 encodings for the EX/MEM stage
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv32_pkg;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_LINK = 2'b10;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } stage_state_e;

endpackage

`default_nettype wire

// File: rtl/branch_cond.sv
//------------------------------------------------------------------------------
// branch_cond : evaluates the RV32I branch condition from funct3 and ALU flags
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_cond
  import rv32_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_c,
  output logic       cond
);

  // C is the carry-out of A + ~B + 1, so C=1 means A >= B unsigned.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      BR_BEQ:  cond = alu_zero;
      BR_BNE:  cond = ~alu_zero;
      BR_BLT:  cond = alu_n ^ alu_v;
      BR_BGE:  cond = ~(alu_n ^ alu_v);
      BR_BLTU: cond = ~alu_c;
      BR_BGEU: cond = alu_c;
      default: cond = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
//------------------------------------------------------------------------------
// ex_mem_stage : branch resolution, PC redirect and EX/MEM pipeline register
// Revision     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_mem_stage
  import rv32_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int KILL_SLOTS = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             ex_valid,
  output logic             ex_stall,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  input  logic             alu_n,
  input  logic             alu_v,
  input  logic             alu_c,
  input  logic             branch,
  input  logic             jump,
  input  logic             jalr,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  pc_target,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic [1:0]       result_src,
  output logic             pc_src,
  output logic [XLEN-1:0]  pc_redirect,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [XLEN-1:0]  mem_result,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [4:0]       mem_rd,
  output logic             mem_reg_write,
  output logic             mem_mem_write,
  output logic [1:0]       mem_result_src,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int KW = (KILL_SLOTS < 2) ? 1 : $clog2(KILL_SLOTS + 1);

  stage_state_e  r_state;
  logic [KW-1:0] r_kill_cnt;

  logic w_cond;
  logic w_advance;
  logic w_squash;
  logic w_live;
  logic w_taken;

  branch_cond u_branch_cond (
    .funct3   (funct3),
    .alu_zero (alu_zero),
    .alu_n    (alu_n),
    .alu_v    (alu_v),
    .alu_c    (alu_c),
    .cond     (w_cond)
  );

  assign w_advance   = ~mem_valid | mem_ready;
  assign w_squash    = (r_state == ST_KILL);
  assign w_live      = ex_valid & ~w_squash & ~flush;
  assign w_taken     = jump | (branch & w_cond);
  assign ex_stall    = mem_valid & ~mem_ready;
  assign pc_src      = w_advance & w_live & w_taken;
  assign pc_redirect = jalr ? {alu_result[XLEN-1:1], 1'b0} : pc_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_wdata      <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_result_src <= '0;
      branch_cnt     <= '0;
      taken_cnt      <= '0;
      r_state        <= ST_RUN;
      r_kill_cnt     <= '0;
    end else if (flush) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_wdata      <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_result_src <= '0;
      r_state        <= ST_RUN;
      r_kill_cnt     <= '0;
    end else begin
      if (w_advance) begin
        mem_valid      <= w_live;
        mem_result     <= jump ? pc_plus4 : alu_result;
        mem_wdata      <= rs2_data;
        mem_rd         <= rd;
        mem_reg_write  <= reg_write & w_live;
        mem_mem_write  <= mem_write & w_live;
        mem_result_src <= result_src;
        if (w_live) begin
          branch_cnt <= branch_cnt + {{(CNT_W-1){1'b0}}, branch};
          taken_cnt  <= taken_cnt + {{(CNT_W-1){1'b0}}, w_taken};
        end
      end

      // Each wrong-path slot that drains out of EX uses up one kill credit.
      case (r_state)
        ST_RUN: begin
          if (pc_src && (KILL_SLOTS != 0)) begin
            r_state    <= ST_KILL;
            r_kill_cnt <= KW'(KILL_SLOTS);
          end
        end
        ST_KILL: begin
          if (w_advance && ex_valid) begin
            if (r_kill_cnt <= KW'(1)) begin
              r_state    <= ST_RUN;
              r_kill_cnt <= '0;
            end else begin
              r_kill_cnt <= r_kill_cnt - KW'(1);
            end
          end
        end
        default: begin
          r_state    <= ST_RUN;
          r_kill_cnt <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
